pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), with reset reset, asynchronous, active-high, and clock clk:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- d_rs1, d_rs2  in  5  source register addresses of the instruction in decode.
- e_rs1, e_rs2  in  5  source register addresses of the instruction in execute.
- e_rd  in  5  execute destination register.
- e_reg_write  in  1  execute instruction writes a register.
- e_mem_read  in  1  execute instruction is a load.
- e_branch_taken  in  1  execute branch or jump resolved taken.
- m_rd  in  5  memory-stage destination register.
- m_reg_write  in  1  memory-stage instruction writes a register.
- m_mem_access  in  1  memory-stage instruction is a load or store.
- w_rd  in  5  writeback destination register.
- w_reg_write  in  1  writeback instruction writes a register.
- dmem_ack  in  1  data memory completes the access this cycle.
- stall_clr  in  1  synchronous clear of stall_cycles.
- dmem_req  out  1  data memory request.
- f_en, d_en, e_en, m_en  out  1  load enables for the PC, IF/ID, ID/EX and EX/DM registers.
- fd_flush, de_flush  out  1  synchronous clear of the IF/ID and ID/EX registers next edge.
- fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 01 writeback, 10 memory stage.
- stall_cycles  out  16  performance counter of stalled cycles.

Function
REQ-002 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-003 The freeze condition SHALL be m_mem_access=1 and dmem_ack=0.
REQ-004 While freeze holds, all four enables SHALL be 0 and both flushes SHALL be 0.
REQ-005 In RUN, freeze SHALL move the FSM to MEM_WAIT.
REQ-006 In MEM_WAIT, dmem_ack=1 SHALL return the FSM to RUN.
REQ-007 dmem_req SHALL equal m_mem_access in RUN and SHALL be 1 in MEM_WAIT.
REQ-008 dmem_req SHALL stay 1 in MEM_WAIT until dmem_ack is sampled 1.
REQ-009 A hit on d_rsX SHALL require a nonzero address equal to a destination whose write flag is set; address x0 never hits.
REQ-010 Load-use SHALL mean e_mem_read=1 and e_reg_write=1 and e_rd hits d_rs1 or d_rs2.
REQ-011 On load-use without freeze: f_en=0, d_en=0, de_flush=1 (bubble), e_en=1, m_en=1.
REQ-012 e_branch_taken without freeze SHALL give fd_flush=1, de_flush=1 and all enables 1.
REQ-013 A taken branch SHALL take priority over load-use.
REQ-014 Freeze SHALL take priority over a taken branch; the branch is acted on in the cycle the freeze ends.
REQ-015 With no hazard, all enables SHALL be 1 and both flushes 0.
REQ-016 In the cycle dmem_ack=1, the enables and flushes SHALL follow REQ-011 to REQ-015.
REQ-017 stall_cycles SHALL increment each cycle f_en=0.
REQ-018 stall_cycles SHALL saturate at 0xFFFF.
REQ-019 stall_clr=1 SHALL load stall_cycles with 0 and take priority over increment.
REQ-020 Enables, flushes, dmem_req and fwd_* SHALL be combinational from the state and inputs, giving zero-cycle latency.

Reset
REQ-021 While reset=1: state=RUN, stall_cycles=0, dmem_req=0, all enables 0, flushes 0, fwd_a=fwd_b=00.
REQ-022 Reset asserted in MEM_WAIT SHALL abort the wait and drop dmem_req immediately.

Configuration
REQ-023 Macro FORWARDING_EN SHALL select the forwarding behaviour.
REQ-024 With FORWARDING_EN defined, fwd_a SHALL be 10 if m_rd hits e_rs1, else 01 if w_rd hits e_rs1, else 00.
REQ-025 With FORWARDING_EN defined, fwd_b SHALL follow the same rule on e_rs2; only load-use stalls.
REQ-026 Without FORWARDING_EN, fwd_a and fwd_b SHALL be fixed at 00.
REQ-027 Without FORWARDING_EN, any hit of d_rs1 or d_rs2 on e_rd or m_rd SHALL stall as in REQ-011; writeback relies on write-before-read.

Verification
REQ-028 The bench SHALL cover: m_mem_access=1, dmem_ack low 3 cycles then high -> dmem_req high 4 cycles, enables 0 for 3 cycles, MEM_WAIT for 3 cycles, stall_cycles=3.
REQ-029 The bench SHALL cover: e_mem_read=1, e_reg_write=1, e_rd=5, d_rs2=5 -> f_en=d_en=0, de_flush=1 for one cycle, stall_cycles +1.
REQ-030 The bench SHALL cover: e_branch_taken=1 together with load-use -> fd_flush=de_flush=1, f_en=1, no stall.
REQ-031 The bench SHALL cover: FORWARDING_EN on, m_rd=w_rd=7 with both writing, e_rs1=7 -> fwd_a=10; m_reg_write=0 -> fwd_a=01; rd=0 -> fwd_a=00.
REQ-032 The bench SHALL cover: reset pulsed in MEM_WAIT -> dmem_req=0 at once and state RUN after release; stall_cycles=0xFFFF plus a stall -> holds 0xFFFF; stall_clr -> 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and memory-wait controller for a five-stage in-order core.
// Produces stage load enables, flushes, the data-memory request, ALU operand
// forwarding selects and a stalled-cycle performance counter.
// Optional feature: define FORWARDING_EN to enable operand forwarding.
// When it is defined, only load-use hazards stall.
// When it is undefined, every decode-stage dependency on the execute or
// memory stage stalls, and fwd_a/fwd_b are tied to 00.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic [4:0]  e_rs1,
  input  logic [4:0]  e_rs2,
  input  logic [4:0]  e_rd,
  input  logic        e_reg_write,
  input  logic        e_mem_read,
  input  logic        e_branch_taken,
  input  logic [4:0]  m_rd,
  input  logic        m_reg_write,
  input  logic        m_mem_access,
  input  logic [4:0]  w_rd,
  input  logic        w_reg_write,
  input  logic        dmem_ack,
  input  logic        stall_clr,
  output logic        dmem_req,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {StRun, StMemWait} state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_q;

  // A source hits a destination only if the register is written and is not x0.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst,
                               input logic we);
    return we && (src != 5'd0) && (src == dst);
  endfunction

  logic freeze;
  logic load_use;
  logic stall_hz;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  assign freeze   = m_mem_access && !dmem_ack;
  assign load_use = e_mem_read && e_reg_write &&
                    (hit(d_rs1, e_rd, 1'b1) || hit(d_rs2, e_rd, 1'b1));

`ifdef FORWARDING_EN
  // Memory stage is the younger result, so it wins over writeback.
  assign fwd_a_c  = hit(e_rs1, m_rd, m_reg_write) ? 2'b10 :
                    hit(e_rs1, w_rd, w_reg_write) ? 2'b01 : 2'b00;
  assign fwd_b_c  = hit(e_rs2, m_rd, m_reg_write) ? 2'b10 :
                    hit(e_rs2, w_rd, w_reg_write) ? 2'b01 : 2'b00;
  assign stall_hz = load_use;
`else
  // Writeback needs no stall: the register file writes before it is read.
  logic unused_fwd;
  assign unused_fwd = ^{e_rs1, e_rs2, w_rd, w_reg_write};
  assign fwd_a_c    = 2'b00;
  assign fwd_b_c    = 2'b00;
  assign stall_hz   = load_use ||
                      hit(d_rs1, e_rd, e_reg_write) || hit(d_rs2, e_rd, e_reg_write) ||
                      hit(d_rs1, m_rd, m_reg_write) || hit(d_rs2, m_rd, m_reg_write);
`endif

  // State register; reset aborts any outstanding memory wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus all combinational control outputs, in priority order:
  // freeze, taken branch, hazard stall, normal flow.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    f_en     = 1'b0;
    d_en     = 1'b0;
    e_en     = 1'b0;
    m_en     = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;

    case (state_q)
      StRun:     if (freeze)   state_d = StMemWait;
      StMemWait: if (dmem_ack) state_d = StRun;
      default:   state_d = StRun;
    endcase

    if (!reset) begin
      dmem_req = (state_q == StMemWait) || m_mem_access;
      fwd_a    = fwd_a_c;
      fwd_b    = fwd_b_c;
      if (freeze) begin
        // Whole pipe holds; outputs already at their frozen defaults.
      end else if (e_branch_taken) begin
        f_en     = 1'b1;
        d_en     = 1'b1;
        e_en     = 1'b1;
        m_en     = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
      end else if (stall_hz) begin
        // Hold fetch/decode and inject a bubble into execute.
        e_en     = 1'b1;
        m_en     = 1'b1;
        de_flush = 1'b1;
      end else begin
        f_en = 1'b1;
        d_en = 1'b1;
        e_en = 1'b1;
        m_en = 1'b1;
      end
    end
  end

  // Saturating count of cycles with fetch held; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else if (stall_clr) begin
      stall_q <= 16'd0;
    end else if (!f_en && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// stimulus compared against a rule-level reference model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic        e_reg_write, e_mem_read, e_branch_taken;
  logic        m_reg_write, m_mem_access, w_reg_write;
  logic        dmem_ack, stall_clr;
  logic        dmem_req, f_en, d_en, e_en, m_en, fd_flush, de_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Reference model state: waiting on memory, and the expected counter.
  bit mw;
  int mc;

  typedef struct packed {
    logic       dmem_req;
    logic       f_en;
    logic       d_en;
    logic       e_en;
    logic       m_en;
    logic       fd_flush;
    logic       de_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } outs_t;

  pipeline_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .d_rs1          (d_rs1),
    .d_rs2          (d_rs2),
    .e_rs1          (e_rs1),
    .e_rs2          (e_rs2),
    .e_rd           (e_rd),
    .e_reg_write    (e_reg_write),
    .e_mem_read     (e_mem_read),
    .e_branch_taken (e_branch_taken),
    .m_rd           (m_rd),
    .m_reg_write    (m_reg_write),
    .m_mem_access   (m_mem_access),
    .w_rd           (w_rd),
    .w_reg_write    (w_reg_write),
    .dmem_ack       (dmem_ack),
    .stall_clr      (stall_clr),
    .dmem_req       (dmem_req),
    .f_en           (f_en),
    .d_en           (d_en),
    .e_en           (e_en),
    .m_en           (m_en),
    .fd_flush       (fd_flush),
    .de_flush       (de_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit hits(logic [4:0] a, logic [4:0] d, logic we);
    return (we == 1'b1) && (a != 5'd0) && (a == d);
  endfunction

  // Expected outputs from the written rules and the current inputs.
  function automatic outs_t model();
    outs_t o;
    bit frz, lu, stall;
    o = '0;
    if (reset) return o;
    frz = m_mem_access && !dmem_ack;
    lu  = e_mem_read && e_reg_write && (hits(d_rs1, e_rd, 1'b1) || hits(d_rs2, e_rd, 1'b1));
`ifdef FORWARDING_EN
    stall = lu;
    o.fwd_a = hits(e_rs1, m_rd, m_reg_write) ? 2'd2 : (hits(e_rs1, w_rd, w_reg_write) ? 2'd1 : 2'd0);
    o.fwd_b = hits(e_rs2, m_rd, m_reg_write) ? 2'd2 : (hits(e_rs2, w_rd, w_reg_write) ? 2'd1 : 2'd0);
`else
    stall = lu || hits(d_rs1, e_rd, e_reg_write) || hits(d_rs2, e_rd, e_reg_write)
               || hits(d_rs1, m_rd, m_reg_write) || hits(d_rs2, m_rd, m_reg_write);
`endif
    o.dmem_req = mw ? 1'b1 : m_mem_access;
    if (frz) begin
      // everything held
    end else if (e_branch_taken) begin
      {o.f_en, o.d_en, o.e_en, o.m_en, o.fd_flush, o.de_flush} = 6'b111111;
    end else if (stall) begin
      {o.f_en, o.d_en, o.e_en, o.m_en, o.fd_flush, o.de_flush} = 6'b001101;
    end else begin
      {o.f_en, o.d_en, o.e_en, o.m_en, o.fd_flush, o.de_flush} = 6'b111100;
    end
    return o;
  endfunction

  // Advance one clock edge, moving the model alongside the DUT.
  task automatic tick();
    outs_t o;
    bit    nw;
    o  = model();
    nw = mw ? !dmem_ack : (m_mem_access && !dmem_ack);
    @(posedge clk);
    if (reset) begin
      mw = 1'b0;
      mc = 0;
    end else begin
      mw = nw;
      if (stall_clr) mc = 0;
      else if (!o.f_en && mc < 65535) mc = mc + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    {d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd} = '0;
    {e_reg_write, e_mem_read, e_branch_taken} = '0;
    {m_reg_write, m_mem_access, w_reg_write} = '0;
    dmem_ack  = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic test_reset();
    outs_t act;
    reset = 1'b1;
    idle_inputs();
    m_mem_access = 1'b1; e_branch_taken = 1'b1; m_rd = 5'd3; m_reg_write = 1'b1; e_rs1 = 5'd3;
    @(negedge clk);
    act = {dmem_req, f_en, d_en, e_en, m_en, fd_flush, de_flush, fwd_a, fwd_b};
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_outs: got %h want 0", act); end
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", stall_cycles); end
    tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({dmem_req, f_en, d_en, e_en, m_en} !== 5'b01111) begin
      bad++; $display("FAIL reset_release: got %b want 01111", {dmem_req, f_en, d_en, e_en, m_en});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    m_mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({dmem_req, f_en, d_en, e_en, m_en, fd_flush, de_flush} !== 7'b1000000) begin
        bad++; $display("FAIL mem_wait_cyc%0d: got %b want 1000000", i,
                        {dmem_req, f_en, d_en, e_en, m_en, fd_flush, de_flush});
      end
      tick();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({dmem_req, f_en, d_en, e_en, m_en} !== 5'b11111) begin
      bad++; $display("FAIL mem_ack_cycle: got %b want 11111", {dmem_req, f_en, d_en, e_en, m_en});
    end
    tick();
    m_mem_access = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (dmem_req !== 1'b0) begin bad++; $display("FAIL mem_back_run: got %b want 0", dmem_req); end
    total++;
    if (stall_cycles !== 16'd3) begin bad++; $display("FAIL mem_stall_cnt: got %0d want 3", stall_cycles); end
    tick();
  endtask

  task automatic test_load_use();
    int base;
    idle_inputs();
    base = mc;
    e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs2 = 5'd5; d_rs1 = 5'd2;
    @(negedge clk);
    total++;
    if ({f_en, d_en, e_en, m_en, fd_flush, de_flush} !== 6'b001101) begin
      bad++; $display("FAIL load_use: got %b want 001101", {f_en, d_en, e_en, m_en, fd_flush, de_flush});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (f_en !== 1'b1) begin bad++; $display("FAIL load_use_release: got %b want 1", f_en); end
    total++;
    if (stall_cycles !== 16'(base + 1)) begin
      bad++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cycles, base + 1);
    end
    // Register x0 never creates a hazard.
    e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd0; d_rs1 = 5'd0;
    #1;
    total++;
    if (f_en !== 1'b1) begin bad++; $display("FAIL load_use_x0: got %b want 1", f_en); end
    tick();
  endtask

  task automatic test_branch();
    int base;
    idle_inputs();
    base = mc;
    e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs2 = 5'd5; e_branch_taken = 1'b1;
    @(negedge clk);
    total++;
    if ({f_en, d_en, e_en, m_en, fd_flush, de_flush} !== 6'b111111) begin
      bad++; $display("FAIL branch_lu: got %b want 111111", {f_en, d_en, e_en, m_en, fd_flush, de_flush});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'(base)) begin
      bad++; $display("FAIL branch_cnt: got %0d want %0d", stall_cycles, base);
    end
    // Freeze masks the branch until the acknowledge arrives.
    e_branch_taken = 1'b1; m_mem_access = 1'b1;
    #1;
    total++;
    if ({f_en, fd_flush, de_flush} !== 3'b000) begin
      bad++; $display("FAIL branch_frozen: got %b want 000", {f_en, fd_flush, de_flush});
    end
    tick();
    dmem_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({f_en, fd_flush, de_flush} !== 3'b111) begin
      bad++; $display("FAIL branch_after_ack: got %b want 111", {f_en, fd_flush, de_flush});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
`ifdef FORWARDING_EN
    m_rd = 5'd7; w_rd = 5'd7; m_reg_write = 1'b1; w_reg_write = 1'b1; e_rs1 = 5'd7; e_rs2 = 5'd7;
    @(negedge clk);
    total++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin bad++; $display("FAIL fwd_mem: got %b want 1010", {fwd_a, fwd_b}); end
    m_reg_write = 1'b0;
    #1;
    total++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin bad++; $display("FAIL fwd_wb: got %b want 0101", {fwd_a, fwd_b}); end
    m_reg_write = 1'b1; m_rd = 5'd0; w_rd = 5'd0; e_rs1 = 5'd0; e_rs2 = 5'd0;
    #1;
    total++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin bad++; $display("FAIL fwd_x0: got %b want 0000", {fwd_a, fwd_b}); end
    // With forwarding a plain dependency does not stall.
    m_rd = 5'd9; d_rs1 = 5'd9; e_rd = 5'd4; e_reg_write = 1'b1; d_rs2 = 5'd4;
    #1;
    total++;
    if (f_en !== 1'b1) begin bad++; $display("FAIL fwd_no_stall: got %b want 1", f_en); end
`else
    m_rd = 5'd9; m_reg_write = 1'b1; d_rs1 = 5'd9; e_rs1 = 5'd9;
    @(negedge clk);
    total++;
    if ({f_en, d_en, de_flush, fwd_a} !== 5'b00100) begin
      bad++; $display("FAIL nofwd_mem_stall: got %b want 00100", {f_en, d_en, de_flush, fwd_a});
    end
    m_reg_write = 1'b0; w_rd = 5'd9; w_reg_write = 1'b1;
    #1;
    total++;
    if ({f_en, fwd_a} !== 3'b100) begin
      bad++; $display("FAIL nofwd_wb_nostall: got %b want 100", {f_en, fwd_a});
    end
    e_rd = 5'd9; e_reg_write = 1'b1;
    #1;
    total++;
    if ({f_en, de_flush} !== 2'b01) begin
      bad++; $display("FAIL nofwd_ex_stall: got %b want 01", {f_en, de_flush});
    end
`endif
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_wait();
    idle_inputs();
    m_mem_access = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({dmem_req, f_en} !== 2'b00) begin
      bad++; $display("FAIL rst_wait_req: got %b want 00", {dmem_req, f_en});
    end
    tick();
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_wait_cnt: got %0d want 0", stall_cycles); end
    reset = 1'b0;
    m_mem_access = 1'b0;
    @(negedge clk);
    total++;
    if ({dmem_req, f_en} !== 2'b01) begin
      bad++; $display("FAIL rst_wait_run: got %b want 01", {dmem_req, f_en});
    end
    tick();
  endtask

  task automatic test_saturate();
    idle_inputs();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    m_mem_access = 1'b1;
    repeat (65535) tick();
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h want ffff", stall_cycles); end
    tick();
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", stall_cycles); end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL sat_clear: got %h want 0", stall_cycles); end
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    outs_t act, exp;
    int    exp_cnt;
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 99) < 2);
      d_rs1          = 5'($urandom_range(0, 3));
      d_rs2          = 5'($urandom_range(0, 3));
      e_rs1          = 5'($urandom_range(0, 3));
      e_rs2          = 5'($urandom_range(0, 3));
      e_rd           = 5'($urandom_range(0, 3));
      m_rd           = 5'($urandom_range(0, 3));
      w_rd           = 5'($urandom_range(0, 3));
      e_reg_write    = 1'($urandom_range(0, 1));
      e_mem_read     = 1'($urandom_range(0, 1));
      e_branch_taken = ($urandom_range(0, 99) < 20);
      m_reg_write    = 1'($urandom_range(0, 1));
      m_mem_access   = ($urandom_range(0, 99) < 35);
      w_reg_write    = 1'($urandom_range(0, 1));
      dmem_ack       = 1'($urandom_range(0, 1));
      stall_clr      = ($urandom_range(0, 99) < 5);
      @(negedge clk);
      exp     = model();
      exp_cnt = reset ? 0 : mc;
      act     = {dmem_req, f_en, d_en, e_en, m_en, fd_flush, de_flush, fwd_a, fwd_b};
      total++;
      if (act !== exp) begin bad++; $display("FAIL rand_outs[%0d]: got %h want %h", i, act, exp); end
      total++;
      if (stall_cycles !== 16'(exp_cnt)) begin
        bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cycles, exp_cnt);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    mw = 1'b0;
    mc = 0;
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_mem_wait();
    test_load_use();
    test_branch();
    test_forwarding();
    test_reset_in_wait();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
